// File: rtl/store_buffer.sv
// Store buffer: holds finished stores until commit, drains them to memory
// in order. Optional load forwarding enabled by STORE_BUFFER_FWD_EN.
module store_buffer #(
    parameter int ENTRY_NUM   = 4,
    parameter int ENTRY_SEL   = 2,
    parameter int DATA_LEN    = 32,
    parameter int ADDR_LEN    = 32,
    parameter int SPECTAG_LEN = 5
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   stfin,
    input  logic [DATA_LEN-1:0]    storedata,
    input  logic [ADDR_LEN-1:0]    storeaddr,
    input  logic [SPECTAG_LEN-1:0] spectag,
    input  logic                   specbit,
    input  logic                   prmiss,
    input  logic [SPECTAG_LEN-1:0] spectagfix,
    input  logic                   stcom,
    input  logic                   memoccupy_ld,
    input  logic [ADDR_LEN-1:0]    ldaddr,
    output logic                   fullsb,
    output logic                   hitsb,
    output logic [DATA_LEN-1:0]    lddatasb,
    output logic                   dmem_we,
    output logic [ADDR_LEN-1:0]    dmem_addr,
    output logic [DATA_LEN-1:0]    dmem_wdata
);

    typedef logic [ENTRY_SEL-1:0] ptr_t;
    typedef logic [ENTRY_SEL:0]   cnt_t;

    ptr_t retptr, comptr, tail;
    cnt_t cnt, ccnt;

    logic [ADDR_LEN-1:0]    addr_q [ENTRY_NUM];
    logic [DATA_LEN-1:0]    data_q [ENTRY_NUM];
    logic [SPECTAG_LEN-1:0] tag_q  [ENTRY_NUM];
    logic                   spec_q [ENTRY_NUM];

    logic do_com, do_ret, do_alloc, in_kill;
    ptr_t comptr_n, tail_base;
    cnt_t ucnt, surv, ccnt_n, cnt_n;

    assign fullsb = (cnt == cnt_t'(ENTRY_NUM));

    always_comb begin
        do_com   = stcom & (cnt != ccnt);
        do_ret   = (ccnt != '0) & ~memoccupy_ld;
        in_kill  = prmiss & specbit & |(spectag & spectagfix);
        do_alloc = stfin & ~fullsb & ~in_kill;
        comptr_n = comptr + ptr_t'(do_com);
        ucnt     = cnt - ccnt - cnt_t'(do_com);
        // Killed entries are a suffix, so counting survivors gives the new tail.
        surv = '0;
        for (int k = 0; k < ENTRY_NUM; k++) begin
            if (cnt_t'(k) < ucnt &&
                !(spec_q[comptr_n + ptr_t'(k)] &&
                  |(tag_q[comptr_n + ptr_t'(k)] & spectagfix)))
                surv = surv + cnt_t'(1);
        end
        tail_base = prmiss ? comptr_n + ptr_t'(surv) : tail;
        ccnt_n    = ccnt + cnt_t'(do_com) - cnt_t'(do_ret);
        cnt_n     = ccnt_n + (prmiss ? surv : ucnt) + cnt_t'(do_alloc);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            retptr <= '0;
            comptr <= '0;
            tail   <= '0;
            cnt    <= '0;
            ccnt   <= '0;
        end else begin
            retptr <= retptr + ptr_t'(do_ret);
            comptr <= comptr_n;
            tail   <= tail_base + ptr_t'(do_alloc);
            cnt    <= cnt_n;
            ccnt   <= ccnt_n;
        end
    end

    always_ff @(posedge clk) begin
        if (do_alloc) begin
            addr_q[tail_base] <= storeaddr;
            data_q[tail_base] <= storedata;
            tag_q[tail_base]  <= spectag;
            spec_q[tail_base] <= specbit;
        end
    end

    assign dmem_we    = do_ret;
    assign dmem_addr  = do_ret ? addr_q[retptr] : '0;
    assign dmem_wdata = do_ret ? data_q[retptr] : '0;

`ifdef STORE_BUFFER_FWD_EN
    // Walk oldest to youngest so the last match wins.
    always_comb begin
        hitsb    = 1'b0;
        lddatasb = '0;
        for (int k = 0; k < ENTRY_NUM; k++) begin
            if (cnt_t'(k) < cnt && addr_q[retptr + ptr_t'(k)] == ldaddr) begin
                hitsb    = 1'b1;
                lddatasb = data_q[retptr + ptr_t'(k)];
            end
        end
    end
`else
    logic unused_ldaddr;
    assign unused_ldaddr = ^ldaddr;
    assign hitsb    = 1'b0;
    assign lddatasb = '0;
`endif

endmodule

// File: tb/tb_store_buffer.sv
// Testbench for store_buffer: queue-based reference model plus
// directed scenarios with literal expectations.
module tb_store_buffer;

    logic        clk = 1'b0;
    logic        reset, stfin, specbit, prmiss, stcom, memoccupy_ld;
    logic [31:0] storedata, storeaddr, ldaddr;
    logic [4:0]  spectag, spectagfix;
    logic        fullsb, hitsb, dmem_we;
    logic [31:0] lddatasb, dmem_addr, dmem_wdata;

    int checks = 0;
    int errors = 0;
    bit chk_on = 1'b0;

`ifdef STORE_BUFFER_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    store_buffer dut (
        .clk(clk), .reset(reset), .stfin(stfin), .storedata(storedata),
        .storeaddr(storeaddr), .spectag(spectag), .specbit(specbit),
        .prmiss(prmiss), .spectagfix(spectagfix), .stcom(stcom),
        .memoccupy_ld(memoccupy_ld), .ldaddr(ldaddr), .fullsb(fullsb),
        .hitsb(hitsb), .lddatasb(lddatasb), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
        logic [4:0]  t;
        logic        s;
        bit          c;
    } ent_t;

    ent_t q[$];

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int ncommitted();
        int n = 0;
        foreach (q[i]) if (q[i].c) n++;
        return n;
    endfunction

    // Reference model update at each edge.
    always @(posedge clk) begin
        int  nc;
        bit  full, ret;
        ent_t e;
        if (reset) begin
            q.delete();
        end else begin
            nc   = ncommitted();
            full = (q.size() == 4);
            ret  = (nc > 0) && !memoccupy_ld;
            if (stcom && nc < q.size()) q[nc].c = 1'b1;
            if (prmiss)
                for (int i = q.size() - 1; i >= 0; i--)
                    if (!q[i].c && q[i].s && |(q[i].t & spectagfix)) q.delete(i);
            if (stfin && !full && !(prmiss && specbit && |(spectag & spectagfix))) begin
                e.a = storeaddr; e.d = storedata; e.t = spectag;
                e.s = specbit; e.c = 1'b0;
                q.push_back(e);
            end
            if (ret) void'(q.pop_front());
        end
    end

    // Compare every cycle against the model.
    always @(negedge clk) begin
        bit          ewe, ehit;
        logic [31:0] ea, ed, eld;
        if (chk_on) begin
            ewe = (ncommitted() > 0) && !memoccupy_ld;
            ea  = ewe ? q[0].a : 32'h0;
            ed  = ewe ? q[0].d : 32'h0;
            ehit = 1'b0;
            eld  = 32'h0;
            if (FWD)
                foreach (q[i])
                    if (q[i].a == ldaddr) begin ehit = 1'b1; eld = q[i].d; end
            check("m_fullsb", fullsb, q.size() == 4);
            check("m_dmem_we", dmem_we, ewe);
            check("m_dmem_addr", dmem_addr, ea);
            check("m_dmem_wdata", dmem_wdata, ed);
            check("m_hitsb", hitsb, ehit);
            check("m_lddatasb", lddatasb, eld);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic st(input logic [31:0] a, input logic [31:0] d,
                      input logic s, input logic [4:0] t);
        stfin = 1'b1; storeaddr = a; storedata = d; specbit = s; spectag = t;
        cyc();
        stfin = 1'b0; specbit = 1'b0; spectag = '0;
    endtask

    task automatic expect_write(input logic [31:0] a, input logic [31:0] d);
        int n = 0;
        bit got = 1'b0;
        while (!got && n < 20) begin
            @(negedge clk);
            if (dmem_we) begin
                got = 1'b1;
                check("wr_addr", dmem_addr, a);
                check("wr_data", dmem_wdata, d);
            end else begin
                n++;
            end
        end
        if (!got) check("wr_timeout", 1'b0, 1'b1);
        cyc();
    endtask

    initial begin
        reset = 1'b1; stfin = 0; specbit = 0; prmiss = 0; stcom = 0;
        memoccupy_ld = 0; storedata = 0; storeaddr = 0; ldaddr = 0;
        spectag = 0; spectagfix = 0;
        cyc();
        chk_on = 1'b1;
        cyc();
        reset = 1'b0;
        @(negedge clk);
        check("rst_fullsb", fullsb, 1'b0);
        check("rst_we", dmem_we, 1'b0);
        check("rst_hit", hitsb, 1'b0);
        cyc();

        // Fill to full; a fifth store is ignored.
        for (int i = 0; i < 4; i++) st(32'h10 + 4 * i, 32'hA0 + i, 1'b0, 5'b0);
        @(negedge clk);
        check("full_after4", fullsb, 1'b1);
        st(32'h40, 32'hEE, 1'b0, 5'b0);
        ldaddr = 32'h40;
        @(negedge clk);
        check("full_after5", fullsb, 1'b1);
        check("fifth_nohit", hitsb, 1'b0);
        ldaddr = 32'h1C;
        @(negedge clk);
        check("fwd_1c", lddatasb, FWD ? 32'hA3 : 32'h0);
        stcom = 1'b1;
        repeat (4) cyc();
        stcom = 1'b0;
        repeat (6) cyc();

        // Youngest match wins.
        st(32'h20, 32'h11, 1'b0, 5'b0);
        st(32'h20, 32'h22, 1'b0, 5'b0);
        ldaddr = 32'h20;
        @(negedge clk);
        check("fwd_hit20", hitsb, FWD);
        check("fwd_data20", lddatasb, FWD ? 32'h22 : 32'h0);
        ldaddr = 32'h24;
        @(negedge clk);
        check("fwd_miss24", hitsb, 1'b0);
        stcom = 1'b1;
        repeat (2) cyc();
        stcom = 1'b0;
        repeat (4) cyc();

        // Drain stalled by load port use.
        st(32'h30, 32'h55, 1'b0, 5'b0);
        stcom = 1'b1; memoccupy_ld = 1'b1;
        cyc();
        stcom = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall_we", dmem_we, 1'b0);
            cyc();
        end
        memoccupy_ld = 1'b0;
        @(negedge clk);
        check("rel_we", dmem_we, 1'b1);
        check("rel_addr", dmem_addr, 32'h30);
        check("rel_data", dmem_wdata, 32'h55);
        cyc();
        ldaddr = 32'h30;
        @(negedge clk);
        check("rel_we_off", dmem_we, 1'b0);
        check("rel_empty", hitsb, 1'b0);
        cyc();

        // Squash B and C; a new store lands right after A.
        st(32'h40, 32'h01, 1'b0, 5'b0);
        st(32'h44, 32'h02, 1'b1, 5'b00010);
        st(32'h48, 32'h03, 1'b1, 5'b00010);
        prmiss = 1'b1; spectagfix = 5'b00010;
        cyc();
        prmiss = 1'b0; spectagfix = '0;
        ldaddr = 32'h48;
        @(negedge clk);
        check("sq_miss48", hitsb, 1'b0);
        ldaddr = 32'h40;
        @(negedge clk);
        check("sq_hit40", hitsb, FWD);
        st(32'h48, 32'h77, 1'b0, 5'b0);
        ldaddr = 32'h48;
        @(negedge clk);
        check("sq_refill", lddatasb, FWD ? 32'h77 : 32'h0);
        stcom = 1'b1;
        repeat (2) cyc();
        stcom = 1'b0;
        repeat (4) cyc();

        // Commit wins over a same-cycle squash.
        st(32'h50, 32'h99, 1'b1, 5'b00001);
        stcom = 1'b1; prmiss = 1'b1; spectagfix = 5'b00001;
        cyc();
        stcom = 1'b0; prmiss = 1'b0; spectagfix = '0;
        expect_write(32'h50, 32'h99);
        repeat (2) cyc();

        // Fill, commit all, drain across the pointer wrap.
        memoccupy_ld = 1'b1;
        for (int i = 0; i < 4; i++) st(32'h60 + 4 * i, 32'hB0 + i, 1'b0, 5'b0);
        @(negedge clk);
        check("wrap_full", fullsb, 1'b1);
        stcom = 1'b1;
        repeat (4) cyc();
        stcom = 1'b0; memoccupy_ld = 1'b0;
        ldaddr = 32'h64;
        for (int i = 0; i < 4; i++) expect_write(32'h60 + 4 * i, 32'hB0 + i);
        @(negedge clk);
        check("wrap_empty_full", fullsb, 1'b0);
        check("wrap_empty_we", dmem_we, 1'b0);
        cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
